// File: rtl/mem_req_scheduler_pkg.sv
// Shared encodings and default sizes for the main-memory request scheduler.
package mem_req_scheduler_pkg;

  localparam int unsigned MEM_LATENCY_DEF    = 5;
  localparam int unsigned PHYS_ADDR_BITS_DEF = 20;
  localparam int unsigned LINE_BITS_DEF      = 128;
  localparam int unsigned AGE_LIMIT_DEF      = 4;
  localparam int unsigned AGE_BITS           = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IC   = 2'd1,
    GNT_DC   = 2'd2
  } gnt_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing the fixed-latency memory access window.
module mem_lat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_req_scheduler.sv
// Arbitrates the single-ported main memory between I-cache fills and
// D-cache fills/write-backs, one fixed-latency transaction at a time.
// Optional I-side anti-starvation aging: define MEM_SCHED_AGING_EN.
module mem_req_scheduler
  import mem_req_scheduler_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int unsigned ADDR_BITS   = PHYS_ADDR_BITS_DEF,
  parameter int unsigned LINE_BITS   = LINE_BITS_DEF
`ifdef MEM_SCHED_AGING_EN
  , parameter int unsigned AGE_LIMIT = AGE_LIMIT_DEF
`endif
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 ic_req,
  input  logic [ADDR_BITS-1:0] ic_addr,
  output logic                 ic_ready,
  output logic [LINE_BITS-1:0] ic_rdata,
  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [ADDR_BITS-1:0] dc_addr,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic                 dc_ready,
  output logic [LINE_BITS-1:0] dc_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  output logic                 busy
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e                 state_q, state_d;
  gnt_e                   gnt_q, gnt_d;
  gnt_e                   pick;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   we_q, we_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic                   cnt_load, cnt_dec, cnt_zero;

  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]   mem_wdata_q, mem_wdata_d;
  logic                   busy_q, busy_d;
  logic                   ic_ready_q, ic_ready_d;
  logic                   dc_ready_q, dc_ready_d;
  logic [LINE_BITS-1:0]   ic_rdata_q, ic_rdata_d;
  logic [LINE_BITS-1:0]   dc_rdata_q, dc_rdata_d;

`ifdef MEM_SCHED_AGING_EN
  logic [AGE_BITS-1:0]    age_q, age_d;

  // Arbitration: D-side first unless the I-side has lost AGE_LIMIT times in a row.
  always_comb begin
    pick  = GNT_NONE;
    age_d = age_q;
    if (ic_req && (age_q == AGE_BITS'(AGE_LIMIT))) pick = GNT_IC;
    else if (dc_req)                              pick = GNT_DC;
    else if (ic_req)                              pick = GNT_IC;
    if (state_q == ST_IDLE) begin
      if (pick == GNT_IC)                 age_d = '0;
      else if (pick == GNT_DC && ic_req)  age_d = age_q + AGE_BITS'(1);
    end
  end

  // Age register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
`else
  // Arbitration: strict D-side priority (memory stage holds the older instruction).
  always_comb begin
    pick = GNT_NONE;
    if (dc_req)      pick = GNT_DC;
    else if (ic_req) pick = GNT_IC;
  end
`endif

  mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clock (clock),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (CNT_W'(MEM_LATENCY - 1)),
    .zero  (cnt_zero)
  );

  // State register plus the latched transaction.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_NONE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state: grant in IDLE, count down in ACCESS, one DONE cycle.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick != GNT_NONE) begin
          state_d  = ST_ACCESS;
          gnt_d    = pick;
          cnt_load = 1'b1;
          if (pick == GNT_DC) begin
            addr_d  = dc_addr;
            we_d    = dc_we;
            wdata_d = dc_wdata;
          end else begin
            addr_d  = ic_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  // Output decode from the next state, so every output leaves a flop.
  always_comb begin
    mem_en_d    = (state_d == ST_ACCESS);
    mem_we_d    = mem_en_d && we_d;
    mem_addr_d  = mem_en_d ? addr_d  : '0;
    mem_wdata_d = mem_en_d ? wdata_d : '0;
    busy_d      = (state_d != ST_IDLE);
    ic_ready_d  = (state_d == ST_DONE) && (gnt_d == GNT_IC);
    dc_ready_d  = (state_d == ST_DONE) && (gnt_d == GNT_DC);
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    if ((state_q == ST_ACCESS) && cnt_zero) begin
      if (gnt_q == GNT_IC)              ic_rdata_d = mem_rdata;
      if ((gnt_q == GNT_DC) && !we_q)   dc_rdata_d = mem_rdata;
    end
  end

  // Output registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      ic_ready_q  <= 1'b0;
      dc_ready_q  <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      ic_ready_q  <= ic_ready_d;
      dc_ready_q  <= dc_ready_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign ic_ready  = ic_ready_q;
  assign dc_ready  = dc_ready_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;

endmodule
